memory_arbiter: RTL

- Shares the core's single-port synchronous RAM between two requesters: port 0 is the core data/instruction path, port 1 is the debug/program loader.
- Grants at most one access per cycle and returns read data one cycle later.
- Bounds how long one owner can hold the RAM when the other port is waiting, so neither port starves.
- Sits between the memory controller and the RAM macro.

---
 rtl/memory_arbiter_pkg.sv | 18 +
 rtl/memory_arbiter_select.sv | 46 ++++
 rtl/memory_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the two-port RAM arbiter.
// Owner encoding, port indices and a port-to-owner helper.
package memory_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN_CORE,
      OWN_DEBUG
   } ArbiterState_t;

   localparam logic PORT_CORE  = 1'b0;
   localparam logic PORT_DEBUG = 1'b1;

   function automatic ArbiterState_t ownerOf(input logic port);
      return port ? OWN_DEBUG : OWN_CORE;
   endfunction

endpackage

// File: rtl/memory_arbiter_select.sv
// memory_arbiter_select: combinational winner and grant pick.
// Owner keeps the RAM until its streak hits MAX_BURST under contention.
module memory_arbiter_select
   import memory_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BC_W      = $clog2(MAX_BURST + 1)
) (
   input  logic [1:0]      req,
   input  ArbiterState_t   owner,
   input  logic [BC_W-1:0] burstCount,
   input  logic            rrPointer,
   output logic            winValid,
   output logic            winner,
   output logic [1:0]      gnt
);

   logic cur;
   logic oth;
   logic keep;

   // Pick the winner: idle ties go to rrPointer, else owner unless its burst is spent.
   always_comb begin
      winValid = 1'b0;
      winner   = PORT_CORE;
      gnt      = 2'b00;
      cur      = (owner == OWN_DEBUG);
      oth      = ~cur;
      keep     = req[cur] &&
                 (!req[oth] || (burstCount < BC_W'(MAX_BURST)));
      if (req == 2'b00) begin
         winValid = 1'b0;
      end else if (owner == IDLE) begin
         winValid = 1'b1;
         winner   = (req == 2'b11) ? rrPointer : req[1];
      end else if (keep) begin
         winValid = 1'b1;
         winner   = cur;
      end else begin
         winValid = 1'b1;
         winner   = oth;
      end
      gnt[winner] = winValid;
   end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one synchronous RAM between core and debug ports.
// One access per cycle, reads return one cycle later on the granted port.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int RAM_A_WIDTH = 12,
   parameter int MAX_BURST   = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [1:0]                  req,
   input  logic [1:0]                  write,
   input  logic [1:0][RAM_A_WIDTH-1:0] addr,
   input  logic [1:0][31:0]            wdata,
   input  logic [1:0][3:0]             byteEnable,
   output logic [1:0]                  gnt,
   output logic [1:0]                  rvalid,
   output logic [31:0]                 rdata,
   output logic [RAM_A_WIDTH-1:0]      ramAddr,
   output logic [31:0]                 ramWdata,
   output logic [3:0]                  ramByteEnable,
   output logic                        ramWriteEnable,
   input  logic [31:0]                 ramRdata
);

   localparam int BC_W = $clog2(MAX_BURST + 1);

   ArbiterState_t   owner;
   ArbiterState_t   ownerNext;
   logic [BC_W-1:0] burstCount;
   logic [BC_W-1:0] burstNext;
   logic            rrPointer;
   logic            rrNext;
   logic [1:0]      rvalidQ;
   logic [1:0]      selGnt;
   logic            winValid;
   logic            winner;
   logic            live;
   logic            muxPort;

   memory_arbiter_select #(
      .MAX_BURST(MAX_BURST),
      .BC_W     (BC_W)
   ) u_select (
      .req       (req),
      .owner     (owner),
      .burstCount(burstCount),
      .rrPointer (rrPointer),
      .winValid  (winValid),
      .winner    (winner),
      .gnt       (selGnt)
   );

   assign live    = winValid & ~reset;
   assign gnt     = reset ? 2'b00 : selGnt;
   assign muxPort = winValid ? winner : PORT_CORE;

   assign ramAddr        = addr[muxPort];
   assign ramWdata       = wdata[muxPort];
   assign ramByteEnable  = byteEnable[muxPort];
   assign ramWriteEnable = live & write[winner];

   assign rdata  = ramRdata;
   assign rvalid = rvalidQ & {2{~reset}};

   // Next owner, streak length and tie-break pointer from this cycle's winner.
   always_comb begin
      ownerNext = owner;
      burstNext = burstCount;
      rrNext    = rrPointer;
      if (!winValid) begin
         ownerNext = IDLE;
         burstNext = '0;
      end else if (owner == ownerOf(winner)) begin
         if (burstCount != BC_W'(MAX_BURST)) begin
            burstNext = burstCount + 1'b1;
         end
      end else begin
         ownerNext = ownerOf(winner);
         burstNext = BC_W'(1);
         rrNext    = ~winner;
      end
   end

   // Arbitration state and one-cycle read-return flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner      <= IDLE;
         burstCount <= '0;
         rrPointer  <= PORT_CORE;
         rvalidQ    <= 2'b00;
      end else begin
         owner      <= ownerNext;
         burstCount <= burstNext;
         rrPointer  <= rrNext;
         rvalidQ    <= gnt & ~write;
      end
   end

endmodule
